// File: rtl/uart_inst_loader_pkg.sv
// Shared types and constants for the UART instruction loader.
// Holds the receiver state encoding, the end-of-image marker and the default baud divisor.
package uart_inst_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    localparam logic [31:0] END_MARKER           = 32'hFFFF_FFFF;
    localparam int          DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: input synchronizer, bit FSM with centre sampling, and an LSB-first shift register.
// The strobe outputs are single-cycle and coincide with the clock in which the deciding sample is taken.
module uart_rx_byte
    import uart_inst_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err_pulse,
    output logic       o_start_ok
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_rx_meta;
    logic             r_rx_s;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_stop_wait;

    logic             w_stop_sample;
    logic             w_start_sample;

    assign w_stop_sample  = (r_state == ST_STOP) && !r_stop_wait && (r_cnt == BIT_LAST);
    assign w_start_sample = (r_state == ST_START) && (r_cnt == HALF_LAST);

    assign o_byte_valid      = w_stop_sample && r_rx_s;
    assign o_frame_err_pulse = w_stop_sample && !r_rx_s;
    assign o_start_ok        = w_start_sample && !r_rx_s;
    assign o_byte_data       = r_shift;

    // After a bad stop bit the line may still be low; r_stop_wait holds us in STOP until it idles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_stop_wait <= 1'b0;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            case (r_state)
                ST_IDLE: begin
                    r_cnt       <= '0;
                    r_stop_wait <= 1'b0;
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_start_sample) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_stop_wait) begin
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_stop_sample) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_stop_wait <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_inst_loader.sv
// Serial boot loader: packs received UART bytes little-endian into 32-bit words and writes them to imem.
// An all-ones word terminates loading; after that only reset re-arms the assembler.
module uart_inst_loader
    import uart_inst_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT               = DEFAULT_CLKS_PER_BIT,
    parameter int INST_MEMORY_ADDR_BUS_WIDTH = 16,
    parameter int INST_MEMORY_DATA_BUS_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rx,
    output logic                                  imem_we,
    output logic [INST_MEMORY_ADDR_BUS_WIDTH-1:0] imem_addr,
    output logic [INST_MEMORY_DATA_BUS_WIDTH-1:0] imem_wdata,
    output logic                                  loading,
    output logic                                  done,
    output logic                                  frame_err
);

    localparam int AW = INST_MEMORY_ADDR_BUS_WIDTH;
    localparam int DW = INST_MEMORY_DATA_BUS_WIDTH;

    logic          w_byte_valid;
    logic [7:0]    w_byte_data;
    logic          w_frame_err_pulse;
    logic          w_start_ok;
    logic [DW-1:0] w_word;

    logic [1:0]    r_byte_idx;
    logic [DW-1:0] r_wdata;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic          r_loading;
    logic          r_done;
    logic          r_frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_rx             (rx),
        .o_byte_valid     (w_byte_valid),
        .o_byte_data      (w_byte_data),
        .o_frame_err_pulse(w_frame_err_pulse),
        .o_start_ok       (w_start_ok)
    );

    always_comb begin
        w_word                     = r_wdata;
        w_word[8*r_byte_idx +: 8]  = w_byte_data;
    end

    // The address advances the cycle after the strobe so it stays stable while imem_we is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx  <= '0;
            r_wdata     <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_loading   <= 1'b0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_we) begin
                r_addr <= r_addr + AW'(4);
            end
            if (w_frame_err_pulse) begin
                r_frame_err <= 1'b1;
            end
            if (w_start_ok && !r_done) begin
                r_loading <= 1'b1;
            end
            if (w_byte_valid && !r_done) begin
                r_wdata    <= w_word;
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) begin
                    if (w_word == END_MARKER) begin
                        r_done    <= 1'b1;
                        r_loading <= 1'b0;
                    end else begin
                        r_we <= 1'b1;
                    end
                end
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign loading    = r_loading;
    assign done       = r_done;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Randomized bench for uart_inst_loader: drives 8N1 frames and compares imem writes and flags against a byte-level model.
// A narrow address bus keeps the wrap-around scenario short.
module tb_uart_inst_loader;

    localparam int CPB = 16;
    localparam int AW  = 7;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic          loading;
    logic          done;
    logic          frame_err;

    int checkCount = 0;
    int errorCount = 0;

    logic [AW-1:0] mAddr;
    logic [31:0]   mWord;
    int            mIdx;
    bit            mDone;
    bit            mLoading;
    bit            mFerr;
    logic [AW-1:0] expAddrQ[$];
    logic [31:0]   expDataQ[$];
    bit            prevWe;

    uart_inst_loader #(
        .CLKS_PER_BIT              (CPB),
        .INST_MEMORY_ADDR_BUS_WIDTH(AW),
        .INST_MEMORY_DATA_BUS_WIDTH(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .loading   (loading),
        .done      (done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Byte-level model: what a received frame should do to the loader's visible state.
    task automatic modelReset();
        mAddr    = '0;
        mWord    = '0;
        mIdx     = 0;
        mDone    = 0;
        mLoading = 0;
        mFerr    = 0;
        expAddrQ.delete();
        expDataQ.delete();
    endtask

    task automatic modelByte(input logic [7:0] b, input bit good);
        if (!mDone) mLoading = 1;
        if (!good) begin
            mFerr = 1;
        end else if (!mDone) begin
            mWord[8*mIdx +: 8] = b;
            if (mIdx == 3) begin
                if (mWord == 32'hFFFF_FFFF) begin
                    mDone    = 1;
                    mLoading = 0;
                end else begin
                    expAddrQ.push_back(mAddr);
                    expDataQ.push_back(mWord);
                    mAddr = mAddr + AW'(4);
                end
            end
            mIdx = (mIdx + 1) % 4;
        end
    endtask

    // Called on a falling edge; leaves rx idle-high after the frame so the next call can start immediately.
    task automatic applyStimulus(input logic [7:0] b, input bit good, input int gap);
        modelByte(b, good);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        if (!good) repeat (2 * CPB) @(negedge clk);
        repeat (gap) @(negedge clk);
    endtask

    task automatic sendWord(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) applyStimulus(w[8*k +: 8], 1'b1, gap);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    task automatic checkFlags(input string name);
        repeat (3 * CPB) @(negedge clk);
        checkOutput({name, ".loading"}, 32'(loading), 32'(mLoading));
        checkOutput({name, ".done"}, 32'(done), 32'(mDone));
        checkOutput({name, ".frameErr"}, 32'(frame_err), 32'(mFerr));
        checkOutput({name, ".pendingWrites"}, 32'(expAddrQ.size()), 0);
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] w;
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h0;
        return w;
    endfunction

    // Every write strobe must match the next expected write in order.
    always @(negedge clk) begin
        if (rst) begin
            prevWe = 0;
        end else begin
            if (imem_we) begin
                checkOutput("weNotBackToBack", 32'(prevWe), 0);
                checkOutput("writeExpected", 32'(expAddrQ.size() > 0), 1);
                if (expAddrQ.size() > 0) begin
                    checkOutput("writeAddr", 32'(imem_addr), 32'(expAddrQ.pop_front()));
                    checkOutput("writeData", imem_wdata, expDataQ.pop_front());
                end
            end
            prevWe = imem_we;
        end
    end

    initial begin
        logic [7:0] bytesA[4];
        modelReset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset.we", 32'(imem_we), 0);
        checkOutput("reset.addr", 32'(imem_addr), 0);
        checkOutput("reset.wdata", imem_wdata, 0);
        checkOutput("reset.loading", 32'(loading), 0);
        checkOutput("reset.done", 32'(done), 0);
        checkOutput("reset.frameErr", 32'(frame_err), 0);

        // Single instruction word.
        bytesA = '{8'h13, 8'h05, 8'h50, 8'h00};
        for (int k = 0; k < 4; k++) applyStimulus(bytesA[k], 1'b1, 0);
        checkFlags("oneWord");

        // Two words, end marker, then a trailing byte that must be ignored.
        applyReset();
        sendWord(randWord(), 0);
        sendWord(randWord(), 1);
        sendWord(32'hFFFF_FFFF, 0);
        applyStimulus(8'h12, 1'b1, 0);
        checkFlags("endMarker");

        // Framing error on a byte that must not occupy a lane.
        applyReset();
        applyStimulus(8'hAB, 1'b0, 0);
        for (int k = 1; k <= 4; k++) applyStimulus(8'(k), 1'b1, 0);
        checkFlags("frameErr");

        // Short low glitch, then a real word to prove the receiver is idle.
        applyReset();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("glitch.loading", 32'(loading), 0);
        checkOutput("glitch.frameErr", 32'(frame_err), 0);
        checkOutput("glitch.noWrite", 32'(expAddrQ.size()), 0);
        sendWord(32'hA5A5_0001, 0);
        checkFlags("afterGlitch");

        // Reset in the middle of a frame discards the partial word.
        applyReset();
        applyStimulus(8'h11, 1'b1, 0);
        applyStimulus(8'h22, 1'b1, 0);
        rx = 1'b0;
        repeat (CPB + 3 * CPB) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        modelReset();
        repeat (2 * CPB) @(negedge clk);
        checkOutput("midReset.loading", 32'(loading), 0);
        checkOutput("midReset.done", 32'(done), 0);
        checkOutput("midReset.frameErr", 32'(frame_err), 0);
        checkOutput("midReset.addr", 32'(imem_addr), 0);
        sendWord(32'hDEAD_BEEF, 0);
        checkFlags("midReset");

        // Random bytes with occasional framing errors and random inter-frame gaps.
        applyReset();
        for (int n = 0; n < 24; n++) begin
            applyStimulus(8'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(0, 3));
        end
        checkFlags("random");

        // Fill the whole (narrowed) address space and one more word to force the wrap.
        applyReset();
        for (int n = 0; n < (1 << AW) / 4 + 1; n++) sendWord(randWord(), $urandom_range(0, 2));
        checkFlags("wrap");
        checkOutput("wrap.nextAddr", 32'(imem_addr), 32'(mAddr));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
